// File: rtl/divmod_pkg.sv
// Shared types and helpers for the dividend-reconstruction (a = q*b + r) block.
package divmod_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Never returns 0, so a WIDTH=1 instance still gets a 1-bit counter.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/divmod_reconstruct_if.sv
// Request/result bundle for divmod_reconstruct; the requester is the master side.
interface divmod_reconstruct_if #(parameter int WIDTH = 64);
    logic             start;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] a;
    logic             ovf;
    logic             rem_err;

    modport master (output start, q, b, r, input busy, done, a, ovf, rem_err);
    modport slave  (input start, q, b, r, output busy, done, a, ovf, rem_err);
endinterface

// File: rtl/shift_add_mul.sv
// LSB-first shift-add multiply-accumulate: acc = r + q*b, one quotient bit per step.
module shift_add_mul
    import divmod_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] r_in,
    output logic [2*WIDTH:0] acc_next,
    output logic             last
);
    localparam int CW = clog2(WIDTH);

    logic [WIDTH-1:0] q_sh;
    logic [WIDTH-1:0] b_sh;
    logic [2*WIDTH:0] acc;
    logic [CW-1:0]    cnt;
    logic [2*WIDTH:0] addend;

    // acc_next is what acc becomes on this step; the top samples it on the final step.
    assign addend   = q_sh[0] ? ((2*WIDTH+1)'(b_sh) << cnt) : '0;
    assign acc_next = acc + addend;
    assign last     = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else if (load) begin
            q_sh <= q_in;
            b_sh <= b_in;
            acc  <= (2*WIDTH+1)'(r_in);
            cnt  <= '0;
        end else if (step) begin
            q_sh <= q_sh >> 1;
            acc  <= acc_next;
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/divmod_reconstruct.sv
// Rebuilds a dividend from quotient, divisor and remainder (a = q*b + r) with
// remainder/divisor validity and overflow flags; one quotient bit per clock.
module divmod_reconstruct
    import divmod_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input logic                 clk,
    input logic                 rst,
    divmod_reconstruct_if.slave bus
);
    state_t           state;
    logic             load;
    logic             step;
    logic             last;
    logic [2*WIDTH:0] acc_next;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] a_q;
    logic             ovf_q;
    logic             rem_err_q;

    assign load = (state == IDLE) && bus.start;
    assign step = (state == CALC);

    shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .q_in     (bus.q),
        .b_in     (bus.b),
        .r_in     (bus.r),
        .acc_next (acc_next),
        .last     (last)
    );

    // Result registers load on the DONE entry edge from the final accumulator value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            a_q       <= '0;
            ovf_q     <= 1'b0;
            rem_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state     <= CALC;
                    busy_q    <= 1'b1;
                    rem_err_q <= (bus.b == '0) || (bus.r >= bus.b);
                end
                CALC: if (last) begin
                    state  <= DONE;
                    done_q <= 1'b1;
                    a_q    <= acc_next[WIDTH-1:0];
                    ovf_q  <= |acc_next[2*WIDTH:WIDTH];
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.a       = a_q;
    assign bus.ovf     = ovf_q;
    assign bus.rem_err = rem_err_q;

endmodule
